// File: rtl/y86_seq_controller.sv
// Multi-cycle sequencer for the Y86 SEQ datapath: steps each instruction through
// Fetch/Decode/Execute/Memory/Writeback/PC-update and owns PC, Stat and the retire count.
module y86_seq_controller #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic [63:0]      valc,
  input  logic [63:0]      valp,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             cnd,
  input  logic [63:0]      valm,
  input  logic             dmem_error,
  output logic [63:0]      pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             wb_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] IC_HALT = 4'h0;
  localparam logic [3:0] IC_JXX  = 4'h7;
  localparam logic [3:0] IC_CALL = 4'h8;
  localparam logic [3:0] IC_RET  = 4'h9;

  // state_q is the FSM state; probe it hierarchically when binding checkers.
  state_t           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       icode_q, icode_d;
  logic [63:0]      valc_q, valc_d;
  logic [63:0]      valp_q, valp_d;
  logic             cnd_q, cnd_d;
  logic [63:0]      valm_q, valm_d;
  logic [63:0]      next_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      cnt_q   <= '0;
      icode_q <= '0;
      valc_q  <= '0;
      valp_q  <= '0;
      cnd_q   <= 1'b0;
      valm_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      icode_q <= icode_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      cnd_q   <= cnd_d;
      valm_q  <= valm_d;
    end
  end

  always_comb begin
    next_pc = valp_q;
    case (icode_q)
      IC_CALL: next_pc = valc_q;
      IC_JXX:  next_pc = cnd_q ? valc_q : valp_q;
      IC_RET:  next_pc = valm_q;
      default: next_pc = valp_q;
    endcase
  end

  // Datapath inputs are sampled only at the posedge that ends the stage that owns them;
  // outside those stages they are ignored, so there is no backpressure.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stat_d     = stat_q;
    cnt_d      = cnt_q;
    icode_d    = icode_q;
    valc_d     = valc_q;
    valp_d     = valp_q;
    cnd_d      = cnd_q;
    valm_d     = valm_q;
    fetch_en   = 1'b0;
    decode_en  = 1'b0;
    execute_en = 1'b0;
    memory_en  = 1'b0;
    wb_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          stat_d  = STAT_AOK;
        end
      end
      S_FETCH: begin
        fetch_en = 1'b1;
        icode_d  = icode;
        valc_d   = valc;
        valp_d   = valp;
        // Faults leave pc at the faulting instruction's address.
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALTED;
        end else if (icode == IC_HALT) begin
          stat_d  = STAT_HLT;
          state_d = S_HALTED;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        decode_en = 1'b1;
        state_d   = S_EXECUTE;
      end
      S_EXECUTE: begin
        execute_en = 1'b1;
        cnd_d      = cnd;
        state_d    = S_MEMORY;
      end
      S_MEMORY: begin
        memory_en = 1'b1;
        valm_d    = valm;
        if (dmem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        wb_en   = 1'b1;
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        pc_d    = next_pc;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  assign pc          = pc_q;
  assign stat        = stat_q;
  assign instr_count = cnt_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_y86_seq_controller.sv
// Directed bench for y86_seq_controller: a driver issues instructions and queues the
// expected architectural result; a monitor checks it on every retire or halt.
module tb_y86_seq_controller;
  localparam int CNT_W = 3;
  localparam int EW    = 64 + 3 + CNT_W;

  localparam logic [29:0] SIG_NORMAL = 30'b01000_00100_00010_00001_00000_10000;
  localparam logic [29:0] SIG_DMEM   = 30'b01000_00100_00010_00000_00000_00000;
  localparam logic [29:0] SIG_FETCHF = 30'b0;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [3:0]       icode;
  logic [63:0]      valc, valp, valm;
  logic             instr_valid, imem_error, cnd, dmem_error;
  logic [63:0]      pc;
  logic             fetch_en, decode_en, execute_en, memory_en, wb_en;
  logic [2:0]       stat;
  logic             busy, halted;
  logic [CNT_W-1:0] instr_count;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  y86_seq_controller #(.RESET_PC(64'd0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .valc(valc), .valp(valp),
    .instr_valid(instr_valid), .imem_error(imem_error), .cnd(cnd), .valm(valm),
    .dmem_error(dmem_error), .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en),
    .execute_en(execute_en), .memory_en(memory_en), .wb_en(wb_en), .stat(stat),
    .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] enables();
    return {fetch_en, decode_en, execute_en, memory_en, wb_en};
  endfunction

  // Monitor: one queue entry per retire (count changes) or per entry into HALTED.
  initial begin
    logic [CNT_W-1:0] prev_cnt;
    logic             prev_halted;
    logic [EW-1:0]    e;
    prev_cnt    = '0;
    prev_halted = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (instr_count != prev_cnt || (halted && !prev_halted))) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 64'(instr_count), 64'(prev_cnt));
        end else begin
          e = exp_q.pop_front();
          check("mon_pc", pc, e[EW-1 -: 64]);
          check("mon_stat", 64'(stat), 64'(e[CNT_W+2 -: 3]));
          check("mon_count", 64'(instr_count), 64'(e[CNT_W-1:0]));
        end
      end
      prev_cnt    = instr_count;
      prev_halted = halted;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    icode = '0; valc = '0; valp = '0; valm = '0;
    instr_valid = 1'b1; imem_error = 1'b0; cnd = 1'b0; dmem_error = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pc", pc, 64'd0);
    check("rst_stat", 64'(stat), 64'd1);
    check("rst_count", 64'(instr_count), 64'd0);
    check("rst_enables", 64'(enables()), 64'd0);
    check("rst_busy_halted", 64'({busy, halted}), 64'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_fetch_en", 64'(fetch_en), 64'd1);
    check("start_pc", pc, 64'd0);
    check("start_busy", 64'(busy), 64'd1);
  endtask

  task automatic issue(input logic [3:0] ic, input logic [63:0] c, input logic [63:0] p,
                       input logic iv, input logic ime, input logic cn, input logic [63:0] m,
                       input logic dme, input logic [63:0] e_pc, input logic [2:0] e_stat,
                       input logic [CNT_W-1:0] e_cnt, input logic [29:0] e_sig);
    logic [29:0] sig;
    int t;
    t = 0;
    while (!fetch_en && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!fetch_en) begin
      check("fetch_wait_timeout", 64'd0, 64'd1);
      return;
    end
    icode = ic; valc = c; valp = p; instr_valid = iv; imem_error = ime;
    cnd = cn; valm = m; dmem_error = dme;
    exp_q.push_back({e_pc, e_stat, e_cnt});
    sig = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sig = {sig[24:0], enables()};
    end
    check("enable_walk", 64'(sig), 64'(e_sig));
  endtask

  initial begin
    int wb_seen;
    do_reset();
    do_start();
    check("start_stat", 64'(stat), 64'd1);
    check("start_count", 64'(instr_count), 64'd0);
    // Normal flow; the 3-bit counter wraps on the 8th retire.
    issue(4'h1, 64'd0,     64'd1,    1, 0, 0, 64'd0,    0, 64'd1,    3'd1, 3'd1, SIG_NORMAL);
    issue(4'h6, 64'd77,    64'd3,    1, 0, 1, 64'd5,    0, 64'd3,    3'd1, 3'd2, SIG_NORMAL);
    issue(4'h7, 64'd65,    64'd9,    1, 0, 1, 64'd0,    0, 64'd65,   3'd1, 3'd3, SIG_NORMAL);
    issue(4'h7, 64'd65,    64'd9,    1, 0, 0, 64'd0,    0, 64'd9,    3'd1, 3'd4, SIG_NORMAL);
    issue(4'h8, 64'd54,    64'd18,   1, 0, 0, 64'd0,    0, 64'd54,   3'd1, 3'd5, SIG_NORMAL);
    issue(4'h9, 64'd0,     64'd55,   1, 0, 1, 64'h20,   0, 64'h20,   3'd1, 3'd6, SIG_NORMAL);
    issue(4'h3, 64'h100,   64'h2a,   1, 0, 1, 64'h99,   0, 64'h2a,   3'd1, 3'd7, SIG_NORMAL);
    issue(4'h1, 64'd0,     64'd5,    1, 0, 0, 64'd0,    0, 64'd5,    3'd1, 3'd0, SIG_NORMAL);
    issue(4'h6, 64'd0,     64'd7,    0, 0, 0, 64'd0,    0, 64'd5,    3'd4, 3'd0, SIG_FETCHF);
    check("ins_halted", 64'(halted), 64'd1);
    // ADR has priority over INS.
    do_reset();
    do_start();
    issue(4'h6, 64'd0,     64'd2,    0, 1, 0, 64'd0,    0, 64'd0,    3'd3, 3'd0, SIG_FETCHF);
    // Data memory fault: no writeback, pc and count unchanged.
    do_reset();
    do_start();
    issue(4'h1, 64'd0,     64'h40,   1, 0, 0, 64'd0,    0, 64'h40,   3'd1, 3'd1, SIG_NORMAL);
    issue(4'h5, 64'h1000,  64'h4a,   1, 0, 0, 64'h33,   1, 64'h40,   3'd3, 3'd1, SIG_DMEM);
    // Halt is sticky; start is ignored.
    do_reset();
    do_start();
    issue(4'h1, 64'd0,     64'd59,   1, 0, 0, 64'd0,    0, 64'd59,   3'd1, 3'd1, SIG_NORMAL);
    issue(4'h0, 64'd0,     64'd60,   1, 0, 0, 64'd0,    0, 64'd59,   3'd2, 3'd1, SIG_FETCHF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("hlt_sticky_halted", 64'(halted), 64'd1);
    check("hlt_sticky_stat", 64'(stat), 64'd2);
    check("hlt_sticky_pc", pc, 64'd59);
    check("hlt_sticky_enables", 64'(enables()), 64'd0);
    do_reset();
    // Reset in EXECUTE aborts the instruction.
    do_start();
    icode = 4'h6; valc = 64'd0; valp = 64'd2; instr_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_in_execute", 64'(execute_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_enables", 64'(enables()), 64'd0);
    check("abort_pc", pc, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    wb_seen = 0;
    repeat (6) begin
      @(negedge clk);
      wb_seen += int'(wb_en);
    end
    check("abort_no_wb", 64'(wb_seen), 64'd0);
    check("abort_count", 64'(instr_count), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/y86_seq_controller.md
Name: y86_seq_controller

Overview:
- Multi-cycle sequencer for the Y86 SEQ datapath (fetch, decode_wb, execute, memory).
- Steps each instruction through the stages as Fetch, Decode, Execute, Memory, Writeback and PC-update, one cycle per stage.
- Owns the architectural PC and the Y86 status code (Stat), computes the next PC, and stops the machine on halt, an invalid instruction or a memory error.
- Replaces the free-running "PC <= ValP every posedge" scheme.

Parameters:
- RESET_PC, 64'd0: PC loaded on rst and used on start.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin execution from RESET_PC; honoured only in IDLE
- icode  in  4  from fetch
- valc  in  64  from fetch
- valp  in  64  from fetch
- instr_valid  in  1  from fetch
- imem_error  in  1  from fetch
- cnd  in  1  from execute
- valm  in  64  from memory
- dmem_error  in  1  from memory
- pc  out  64  current PC driven to fetch
- fetch_en  out  1  stage enable
- decode_en  out  1  stage enable
- execute_en  out  1  stage enable
- memory_en  out  1  stage enable
- wb_en  out  1  register-file write enable
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- busy  out  1  high in any state except IDLE and HALTED
- halted  out  1  high in HALTED
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst sampled high at a posedge): state=IDLE, pc=RESET_PC, stat=AOK, instr_count=0, all enables 0, busy=0, halted=0, latched icode/valc/valp/cnd/valm cleared. rst overrides start and any in-flight instruction; a partially executed instruction produces no wb_en.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED. Encoding is implementer's choice.
- Enables are Moore outputs: fetch_en=1 only in FETCH, decode_en only in DECODE, execute_en only in EXECUTE, memory_en only in MEMORY, wb_en only in WRITEBACK.
- IDLE: on start=1 go to FETCH with pc=RESET_PC, stat=AOK. Otherwise stay.
- FETCH: at the end of the cycle, latch icode, valc and valp. Check in priority order:
  - imem_error=1: stat=ADR, go to HALTED.
  - else instr_valid=0: stat=INS, go to HALTED.
  - else icode=0 (halt): stat=HLT, go to HALTED.
  - else go to DECODE.
  - In all three error/halt cases pc keeps the faulting instruction's address.
- DECODE: go to EXECUTE. EXECUTE: latch cnd, go to MEMORY.
- MEMORY: latch valm.
  - If dmem_error=1: stat=ADR, go to HALTED; WRITEBACK is skipped and pc is unchanged.
  - Otherwise go to WRITEBACK.
- WRITEBACK: go to PCUPD.
- PCUPD: load pc with the next PC:
  - icode=8 (call): valc
  - icode=7 (jXX) and cnd=1: valc
  - icode=9 (ret): valm
  - otherwise: valp
  - In the same cycle, increment instr_count, wrapping modulo 2^CNT_W, then go to FETCH.
- Latency: 6 cycles per instruction; a retire happens every 6th posedge while running.
- HALTED: sticky; only rst leaves it. start is ignored. No enable is asserted. halt, INS and ADR instructions do not increment instr_count.
- pc arithmetic is 64-bit with no wrap checks; the next-PC value is taken verbatim.
- Inputs are sampled only in the states listed above and are don't-care otherwise.

Test Plan:
- rst=1 for 2 cycles, then start pulse with RESET_PC=0 → pc=0, fetch_en=1 on the next cycle, stat=1, busy=1, instr_count=0.
- nop (icode=1, valp=1) followed by addq (icode=6, valp=3) → enables walk F→D→E→M→W over 6 cycles per instruction; after 12 cycles pc=3 and instr_count=2.
- jXX: icode=7, valc=65, valp=9 → with cnd=1 pc becomes 65; with cnd=0 pc becomes 9. call (icode=8, valc=54) → pc=54. ret (icode=9, valm=0x20) → pc=0x20.
- Fault cases:
  - instr_valid=0 at pc=5 → stat=4, halted=1, pc stays 5, no wb_en ever asserted.
  - imem_error=1 with instr_valid=0 together → stat=3, since ADR has priority.
  - dmem_error=1 in MEMORY → stat=3, no wb_en, instr_count unchanged.
- icode=0 at pc=59 → stat=2, halted=1, pc=59; a later start pulse is ignored; rst then returns to IDLE with stat=1.
- rst asserted during EXECUTE → next cycle IDLE, all enables 0, pc=RESET_PC, no wb_en from the aborted instruction.
